dmem_arbiter: RTL and testbench

Two-port round-robin arbiter and clear sequencer in front of the 64×8 data memory. Shares the single RAM port between port 0 (pipeline MEM stage) and port 1 (program/debug loader) using a req/gnt handshake. After reset, and on request, it walks all 64 addresses writing zero, so the RAM's own synchronous reset is never used. Sits between the requesters and the `ram` instance; it drives every RAM input.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter_rr_arb2.sv | 42 ++++
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and FSM state type for the data-memory arbiter.
package dmem_pkg;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    StInit,
    StClear,
    StServe
  } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: req/gnt handshake plus read return.
interface dmem_arbiter_if;
  import dmem_pkg::*;

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant with its priority register; grants only while en is high.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_q, prio_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // The port just served drops to the lower priority.
  always_comb begin
    prio_d = prio_q;
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single 64x8 RAM port between two requesters and zero-fills the RAM
// after reset or on clr_req, so the RAM's own reset is never used.
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  p0,
  dmem_arbiter_if.slave  p1,
  input  logic           clr_req,
  output logic           busy,
  output logic [AW-1:0]  ram_a,
  output logic [DW-1:0]  ram_d,
  output logic           ram_we,
  output logic           ram_re,
  output logic           ram_rst,
  input  logic [DW-1:0]  ram_q
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0]    gnt;
  logic [1:0]    rd_gnt;
  logic [1:0]    rvalid_q;
  logic [DW-1:0] p0_rdata_q, p1_rdata_q;
  logic          arb_en;

  assign arb_en = (state_q == StServe) && !clr_req;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   ({p1.req, p0.req}),
    .gnt   (gnt)
  );

  assign rd_gnt = gnt & {~p1.we, ~p0.we};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: state_d = StClear;
      StClear: begin
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = StServe;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      StServe: begin
        if (clr_req) begin
          state_d = StClear;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // Outputs: RAM mux
  always_comb begin
    ram_a  = '0;
    ram_d  = '0;
    ram_we = 1'b0;
    ram_re = 1'b0;
    unique case (state_q)
      StClear: begin
        ram_a  = cnt_q;
        ram_we = 1'b1;
      end
      StServe: begin
        if (gnt[0]) begin
          ram_a  = p0.addr;
          ram_d  = p0.wdata;
          ram_we = p0.we;
          ram_re = ~p0.we;
        end else if (gnt[1]) begin
          ram_a  = p1.addr;
          ram_d  = p1.wdata;
          ram_we = p1.we;
          ram_re = ~p1.we;
        end
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != StServe);
  assign ram_rst = 1'b0;

  // Read return; rvalid is registered so a following clear cannot swallow it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q   <= 2'b00;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      rvalid_q <= rd_gnt;
      if (rd_gnt[0]) begin
        p0_rdata_q <= ram_q;
      end
      if (rd_gnt[1]) begin
        p1_rdata_q <= ram_q;
      end
    end
  end

  assign p0.gnt    = gnt[0];
  assign p1.gnt    = gnt[1];
  assign p0.rvalid = rvalid_q[0];
  assign p1.rvalid = rvalid_q[1];
  assign p0.rdata  = p0_rdata_q;
  assign p1.rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 64x8 RAM.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          clr_req;
  logic          busy;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic          ram_we;
  logic          ram_re;
  logic          ram_rst;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] mem [DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter_if p0_if ();
  dmem_arbiter_if p1_if ();

  dmem_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .p0      (p0_if),
    .p1      (p1_if),
    .clr_req (clr_req),
    .busy    (busy),
    .ram_a   (ram_a),
    .ram_d   (ram_d),
    .ram_we  (ram_we),
    .ram_re  (ram_re),
    .ram_rst (ram_rst),
    .ram_q   (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
  end
  assign ram_q = mem[ram_a];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (k == 0) begin
      p0_if.req = req; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wdata;
    end else begin
      p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wdata;
    end
  endtask

  // Counts busy and RAM-write cycles; returns at the negedge of the first SERVE cycle.
  task automatic run_clear(input int exp_busy);
    int nb = 0;
    int nw = 0;
    bit addr_ok = 1'b1;
    bit gnt_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (p0_if.gnt || p1_if.gnt) gnt_ok = 1'b0;
      if (ram_we) begin
        if (ram_a != nw[5:0] || ram_d != 8'h00) addr_ok = 1'b0;
        nw++;
      end
      @(posedge clk);
      #1;
    end
    chk("clr_busy_cycles", 32'(nb), 32'(exp_busy));
    chk("clr_we_cycles", 32'(nw), 32'd64);
    chk("clr_addr_seq", 32'(addr_ok), 32'd1);
    chk("clr_no_grant", 32'(gnt_ok), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'hFF;
    rst_n   = 1'b0;
    clr_req = 1'b0;
    drive(0, 1'b0, 1'b0, 6'd0, 8'h00);
    drive(1, 1'b0, 1'b0, 6'd0, 8'h00);
    #2;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_re", 32'(ram_re), 32'd0);
    chk("rst_ram_a", 32'(ram_a), 32'd0);
    chk("rst_ram_rst", 32'(ram_rst), 32'd0);
    chk("rst_p0_rvalid", 32'(p0_if.rvalid), 32'd0);
    chk("rst_p1_rdata", 32'(p1_if.rdata), 32'd0);

    // p1 holds a read of 63 through the whole initial clear
    drive(1, 1'b1, 1'b0, 6'd63, 8'h00);
    tick();
    rst_n = 1'b1;
    run_clear(65);
    chk("first_serve_p1_gnt", 32'(p1_if.gnt), 32'd1);
    chk("first_serve_ram_re", 32'(ram_re), 32'd1);
    chk("first_serve_ram_a", 32'(ram_a), 32'd63);
    tick();
    drive(1, 1'b0, 1'b0, 6'd0, 8'h00);
    chk("rd63_p1_rvalid", 32'(p1_if.rvalid), 32'd1);
    chk("rd63_p1_rdata", 32'(p1_if.rdata), 32'h00);
    chk("rd63_p0_rvalid", 32'(p0_if.rvalid), 32'd0);

    // p0 writes A5 to 5, p1 reads it back
    drive(0, 1'b1, 1'b1, 6'd5, 8'hA5);
    @(negedge clk);
    chk("wr5_p0_gnt", 32'(p0_if.gnt), 32'd1);
    chk("wr5_ram_we", 32'(ram_we), 32'd1);
    chk("wr5_ram_a", 32'(ram_a), 32'd5);
    chk("wr5_ram_d", 32'(ram_d), 32'hA5);
    tick();
    drive(0, 1'b0, 1'b0, 6'd0, 8'h00);
    drive(1, 1'b1, 1'b0, 6'd5, 8'h00);
    @(negedge clk);
    chk("rd5_p1_gnt", 32'(p1_if.gnt), 32'd1);
    chk("rd5_ram_re", 32'(ram_re), 32'd1);
    chk("rd5_ram_we", 32'(ram_we), 32'd0);
    tick();
    drive(1, 1'b0, 1'b0, 6'd0, 8'h00);
    chk("rd5_p1_rvalid", 32'(p1_if.rvalid), 32'd1);
    chk("rd5_p1_rdata", 32'(p1_if.rdata), 32'hA5);
    chk("rd5_p0_rvalid", 32'(p0_if.rvalid), 32'd0);
    tick();
    chk("rd5_p1_rvalid_pulse", 32'(p1_if.rvalid), 32'd0);

    // Seed addresses 1 and 2 from p1, leaving prio at port 0
    drive(1, 1'b1, 1'b1, 6'd1, 8'h11);
    tick();
    drive(1, 1'b1, 1'b1, 6'd2, 8'h22);
    tick();
    drive(0, 1'b1, 1'b0, 6'd1, 8'h00);
    drive(1, 1'b1, 1'b0, 6'd2, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_p0_gnt", 32'(p0_if.gnt), 32'(i % 2 == 0));
      chk("alt_p1_gnt", 32'(p1_if.gnt), 32'(i % 2 == 1));
      tick();
      if (i % 2 == 0) begin
        chk("alt_p0_rvalid", 32'(p0_if.rvalid), 32'd1);
        chk("alt_p0_rdata", 32'(p0_if.rdata), 32'h11);
        chk("alt_p1_idle", 32'(p1_if.rvalid), 32'd0);
      end else begin
        chk("alt_p1_rvalid", 32'(p1_if.rvalid), 32'd1);
        chk("alt_p1_rdata", 32'(p1_if.rdata), 32'h22);
        chk("alt_p0_idle", 32'(p0_if.rvalid), 32'd0);
      end
    end
    drive(0, 1'b0, 1'b0, 6'd0, 8'h00);
    drive(1, 1'b0, 1'b0, 6'd0, 8'h00);

    // clr_req beats a simultaneous p0 request
    drive(0, 1'b1, 1'b1, 6'd10, 8'h3C);
    tick();
    drive(0, 1'b1, 1'b0, 6'd10, 8'h00);
    clr_req = 1'b1;
    @(negedge clk);
    chk("clr_p0_gnt", 32'(p0_if.gnt), 32'd0);
    chk("clr_busy_pre", 32'(busy), 32'd0);
    chk("clr_ram_we_pre", 32'(ram_we), 32'd0);
    tick();
    clr_req = 1'b0;
    run_clear(64);
    chk("postclr_p0_gnt", 32'(p0_if.gnt), 32'd1);
    chk("postclr_ram_a", 32'(ram_a), 32'd10);
    tick();
    drive(0, 1'b0, 1'b0, 6'd0, 8'h00);
    chk("postclr_p0_rvalid", 32'(p0_if.rvalid), 32'd1);
    chk("postclr_p0_rdata", 32'(p0_if.rdata), 32'h00);

    // Read grant right before a clear still returns its data
    drive(1, 1'b1, 1'b1, 6'd7, 8'h5A);
    tick();
    drive(1, 1'b1, 1'b0, 6'd7, 8'h00);
    @(negedge clk);
    chk("rd7_p1_gnt", 32'(p1_if.gnt), 32'd1);
    tick();
    drive(1, 1'b0, 1'b0, 6'd0, 8'h00);
    clr_req = 1'b1;
    chk("rd7_p1_rvalid", 32'(p1_if.rvalid), 32'd1);
    chk("rd7_p1_rdata", 32'(p1_if.rdata), 32'h5A);
    @(negedge clk);
    chk("rd7_busy_serve", 32'(busy), 32'd0);
    tick();
    clr_req = 1'b0;
    chk("rd7_busy_clear", 32'(busy), 32'd1);
    chk("rd7_rvalid_done", 32'(p1_if.rvalid), 32'd0);

    // Reset in the middle of the clear
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    chk("midclr_ram_a", 32'(ram_a), 32'd20);
    chk("midclr_ram_we", 32'(ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_ram_we", 32'(ram_we), 32'd0);
    chk("midrst_ram_a", 32'(ram_a), 32'd0);
    chk("midrst_p1_rdata", 32'(p1_if.rdata), 32'h00);
    tick();
    rst_n = 1'b1;
    run_clear(65);
    drive(0, 1'b1, 1'b0, 6'd7, 8'h00);
    #1;
    chk("final_p0_gnt", 32'(p0_if.gnt), 32'd1);
    tick();
    drive(0, 1'b0, 1'b0, 6'd0, 8'h00);
    chk("final_p0_rvalid", 32'(p0_if.rvalid), 32'd1);
    chk("final_p0_rdata", 32'(p0_if.rdata), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
